// File: rtl/manta_eot_monitor.sv
// rtl/manta_eot_monitor.sv - end-of-test store monitor for the manta data-memory write port
// Watches stores, counts run cycles and stores, folds stores into a signature, flags done or timeout.
module manta_eot_monitor #(
   parameter logic [15:0] EOT_ADDR       = 16'hD074,
   parameter logic [15:0] EOT_DATA       = 16'hD074,
   parameter int unsigned DRAIN_CYCLES   = 5,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mem_wr_en,
   input  logic [15:0] mem_wr_dest,
   input  logic [15:0] mem_wr_data,
   output logic        busy,
   output logic        eot_seen,
   output logic        done,
   output logic        timed_out,
   output logic [31:0] cycle_count,
   output logic [15:0] store_count,
   output logic [15:0] signature
);

   localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST =
      (DRAIN_CYCLES == 0) ? '0 : DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST =
      (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE,
      S_TIMEOUT
   } state_t;

   state_t               state_q, state_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic                 eot_seen_q, eot_seen_d;
   logic                 done_q, done_d;
   logic                 timed_out_q, timed_out_d;
   logic [31:0]          cycle_q, cycle_d;
   logic [15:0]          store_q, store_d;
   logic [15:0]          sig_q, sig_d;
   logic                 marker;
   logic                 plain_store;

   assign marker      = mem_wr_en && (mem_wr_dest == EOT_ADDR) && (mem_wr_data == EOT_DATA);
   assign plain_store = mem_wr_en && !marker;

   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      eot_seen_d  = eot_seen_q;
      done_d      = done_q;
      timed_out_d = timed_out_q;
      cycle_d     = cycle_q;
      store_d     = store_q;
      sig_d       = sig_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cycle_q != 32'hFFFF_FFFF) begin
               cycle_d = cycle_q + 32'd1;
            end
            // The marker takes priority over a timeout landing on the same edge.
            if (marker) begin
               eot_seen_d = 1'b1;
               if (DRAIN_CYCLES == 0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_DRAIN;
                  drain_d = '0;
               end
            end else begin
               if (plain_store) begin
                  if (store_q != 16'hFFFF) begin
                     store_d = store_q + 16'd1;
                  end
                  sig_d = {sig_q[14:0], sig_q[15]} ^ mem_wr_dest ^ mem_wr_data;
               end
               if ((TIMEOUT_CYCLES != 0) && (cycle_q == TIMEOUT_LAST)) begin
                  state_d     = S_TIMEOUT;
                  timed_out_d = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         drain_q     <= '0;
         eot_seen_q  <= 1'b0;
         done_q      <= 1'b0;
         timed_out_q <= 1'b0;
         cycle_q     <= '0;
         store_q     <= '0;
         sig_q       <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         eot_seen_q  <= eot_seen_d;
         done_q      <= done_d;
         timed_out_q <= timed_out_d;
         cycle_q     <= cycle_d;
         store_q     <= store_d;
         sig_q       <= sig_d;
      end
   end

   assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign eot_seen    = eot_seen_q;
   assign done        = done_q;
   assign timed_out   = timed_out_q;
   assign cycle_count = cycle_q;
   assign store_count = store_q;
   assign signature   = sig_q;

endmodule
